// File: rtl/dvp_pkg.sv
// dvp_pkg: shared state encoding, entry flag positions and error bit indices for the DVP frame controller
package dvp_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_CNT_W  = 16;

    // Flag positions are offsets above the data bits of an entry
    localparam int VSYNC_OFS = 1;
    localparam int HSYNC_OFS = 0;

    localparam int ERR_LINE_LEN    = 0;
    localparam int ERR_SHORT_FRAME = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_SOF,
        ST_CAPTURE
    } state_t;

    typedef enum logic [1:0] {
        ENT_EOL,
        ENT_PIX,
        ENT_SOF
    } entry_t;

    function automatic entry_t entry_kind(input logic vsync, input logic hsync);
        return vsync ? ENT_SOF : (hsync ? ENT_PIX : ENT_EOL);
    endfunction

endpackage

// File: rtl/dvp_line_checker.sv
// dvp_line_checker: counts bytes per line and lines per frame, flags bad line length and frame end
module dvp_line_checker #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             byte_inc,
    input  logic             eol,
    input  logic [CNT_W-1:0] line_len,
    input  logic [CNT_W-1:0] frame_h,
    output logic             line_err,
    output logic             frame_end
);

    logic [CNT_W-1:0] byte_cnt;
    logic [CNT_W-1:0] line_cnt;
    logic [CNT_W-1:0] line_nxt;

    assign line_nxt  = line_cnt + 1'b1;
    assign line_err  = eol && byte_cnt != line_len;
    assign frame_end = eol && line_nxt == frame_h;

    // Byte count saturates; an EOL closes the line and advances the line count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt <= '0;
            line_cnt <= '0;
        end else if (clr) begin
            byte_cnt <= '0;
            line_cnt <= '0;
        end else if (eol) begin
            byte_cnt <= '0;
            line_cnt <= frame_end ? '0 : line_nxt;
        end else if (byte_inc && byte_cnt != '1) begin
            byte_cnt <= byte_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dvp_frame_ctrl.sv
// dvp_frame_ctrl: gates DVP capture to whole frames, forwards pixel bytes and checks frame geometry
module dvp_frame_ctrl
    import dvp_pkg::*;
#(
    parameter int DVP_DATA_W = DEF_DATA_W,
    parameter int PXL_INFO_W = DVP_DATA_W + 2,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [PXL_INFO_W-1:0] pxl_info_i,
    input  logic                  pxl_info_vld_i,
    output logic                  pxl_info_rdy_o,
    output logic [PXL_INFO_W-1:0] pxl_info_o,
    output logic                  pxl_info_vld_o,
    input  logic                  pxl_info_rdy_i,
    input  logic                  dcr_cam_start_i,
    input  logic                  dcr_cam_stop_i,
    input  logic                  dcr_single_i,
    input  logic [CNT_W-1:0]      dcr_line_len_i,
    input  logic [CNT_W-1:0]      dcr_frame_h_i,
    input  logic                  dcr_err_clr_i,
    output logic                  busy_o,
    output logic                  frame_done_o,
    output logic [CNT_W-1:0]      frame_cnt_o,
    output logic [1:0]            err_flags_o,
    output logic                  err_irq_o
);

    state_t           state;
    state_t           state_nxt;
    entry_t           kind;
    logic             single_q;
    logic [CNT_W-1:0] line_len_q;
    logic [CNT_W-1:0] frame_h_q;
    logic             stop_pend;
    logic             stop_pend_nxt;
    logic             capture;
    logic             pix;
    logic             launch;
    logic             sof_hs;
    logic             eol_hs;
    logic             line_err;
    logic             frame_end;
    logic [1:0]       err_new;

    assign kind    = entry_kind(pxl_info_i[DVP_DATA_W+VSYNC_OFS], pxl_info_i[DVP_DATA_W+HSYNC_OFS]);
    assign capture = state == ST_CAPTURE;
    assign pix     = capture && kind == ENT_PIX;
    assign launch  = state == ST_IDLE && dcr_cam_start_i && !dcr_cam_stop_i;
    assign sof_hs  = state != ST_IDLE && pxl_info_vld_i && kind == ENT_SOF;
    assign eol_hs  = capture && pxl_info_vld_i && kind == ENT_EOL;

    // Only pixel bytes seen while capturing reach downstream; everything else is drained
    assign pxl_info_o     = pxl_info_i;
    assign pxl_info_vld_o = pix && pxl_info_vld_i;
    assign pxl_info_rdy_o = pix ? pxl_info_rdy_i : 1'b1;
    assign busy_o         = state != ST_IDLE;

    assign err_new[ERR_LINE_LEN]    = line_err;
    assign err_new[ERR_SHORT_FRAME] = capture && sof_hs;

    dvp_line_checker #(
        .CNT_W(CNT_W)
    ) u_line_checker (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (sof_hs),
        .byte_inc (pxl_info_vld_o && pxl_info_rdy_i),
        .eol      (eol_hs),
        .line_len (line_len_q),
        .frame_h  (frame_h_q),
        .line_err (line_err),
        .frame_end(frame_end)
    );

    // Next state; a stop during capture is deferred until the current frame completes
    always_comb begin
        state_nxt     = state;
        stop_pend_nxt = stop_pend;
        case (state)
            ST_IDLE:     state_nxt = launch ? ST_WAIT_SOF : ST_IDLE;
            ST_WAIT_SOF: state_nxt = dcr_cam_stop_i ? ST_IDLE : (sof_hs ? ST_CAPTURE : ST_WAIT_SOF);
            ST_CAPTURE: begin
                stop_pend_nxt = stop_pend || dcr_cam_stop_i;
                if (frame_end)
                    state_nxt = (single_q || stop_pend_nxt) ? ST_IDLE : ST_WAIT_SOF;
            end
            default:     state_nxt = ST_IDLE;
        endcase
        if (state_nxt == ST_IDLE)
            stop_pend_nxt = 1'b0;
    end

    // State register and pending stop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            stop_pend <= 1'b0;
        end else begin
            state     <= state_nxt;
            stop_pend <= stop_pend_nxt;
        end
    end

    // Configuration is frozen at start so mid-capture register writes cannot skew a frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            single_q   <= 1'b0;
            line_len_q <= '0;
            frame_h_q  <= '0;
        end else if (launch) begin
            single_q   <= dcr_single_i;
            line_len_q <= dcr_line_len_i;
            frame_h_q  <= dcr_frame_h_i;
        end
    end

    // Frame completion, sticky errors (new events beat a clear) and interrupt pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done_o <= 1'b0;
            frame_cnt_o  <= '0;
            err_flags_o  <= '0;
            err_irq_o    <= 1'b0;
        end else begin
            frame_done_o <= frame_end;
            frame_cnt_o  <= frame_cnt_o + CNT_W'(frame_end);
            err_flags_o  <= (dcr_err_clr_i ? 2'b00 : err_flags_o) | err_new;
            err_irq_o    <= |err_new;
        end
    end

endmodule

// File: tb/tb_dvp_frame_ctrl.sv
// tb_dvp_frame_ctrl: randomized frame traffic checked against a per-entry behavioural model
module tb_dvp_frame_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  info = '0;
    logic        vld = 1'b0;
    logic        rdy_i = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        single = 1'b0;
    logic        clr = 1'b0;
    logic [15:0] llen = 16'd1;
    logic [15:0] fh = 16'd1;
    logic        rdy_o;
    logic [9:0]  info_o;
    logic        vld_o;
    logic        busy;
    logic        done_o;
    logic [15:0] fcnt_o;
    logic [1:0]  flags_o;
    logic        irq_o;

    dvp_frame_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pxl_info_i     (info),
        .pxl_info_vld_i (vld),
        .pxl_info_rdy_o (rdy_o),
        .pxl_info_o     (info_o),
        .pxl_info_vld_o (vld_o),
        .pxl_info_rdy_i (rdy_i),
        .dcr_cam_start_i(start),
        .dcr_cam_stop_i (stop),
        .dcr_single_i   (single),
        .dcr_line_len_i (llen),
        .dcr_frame_h_i  (fh),
        .dcr_err_clr_i  (clr),
        .busy_o         (busy),
        .frame_done_o   (done_o),
        .frame_cnt_o    (fcnt_o),
        .err_flags_o    (flags_o),
        .err_irq_o      (irq_o)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;
    bit          m_on, m_frame, m_pend, m_single, consumed;
    int          m_llen, m_fh, m_bytes, m_lines;
    logic [15:0] m_fcnt;
    logic [1:0]  m_flags;
    int          fwd_exp = 0;
    int          fwd_dut = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_on = 0; m_frame = 0; m_pend = 0; m_single = 0;
        m_bytes = 0; m_lines = 0; m_fcnt = '0; m_flags = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rdy_o"}, rdy_o, 1);
        check({tag, "_vld_o"}, vld_o, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done_o, 0);
        check({tag, "_irq"}, irq_o, 0);
        check({tag, "_fcnt"}, fcnt_o, 0);
        check({tag, "_flags"}, flags_o, 0);
    endtask

    // One clock: check the combinational handshake, apply the spec rules to the consumed entry, check registered outputs
    task automatic tick();
        bit sof, pix, eol, ev, er, done;
        logic [1:0] errs;
        @(negedge clk);
        sof = info[9];
        pix = !info[9] && info[8];
        eol = !info[9] && !info[8];
        ev = m_frame && pix && vld;
        er = (m_frame && pix) ? rdy_i : 1'b1;
        check("vld_o", vld_o, ev);
        check("rdy_o", rdy_o, er);
        if (ev) check("data_o", info_o, info);
        if (vld_o && rdy_i) fwd_dut++;
        consumed = vld && er;
        errs = 2'b00;
        done = 0;
        if (!m_on) begin
            if (start && !stop) begin
                m_on = 1; m_frame = 0; m_single = single; m_llen = llen; m_fh = fh;
            end
        end else if (!m_frame) begin
            if (stop) m_on = 0;
            else if (vld && sof) begin m_frame = 1; m_bytes = 0; m_lines = 0; end
        end else begin
            if (stop) m_pend = 1;
            if (vld && sof) begin
                errs[1] = 1'b1; m_bytes = 0; m_lines = 0;
            end else if (vld && pix && rdy_i) begin
                if (m_bytes < 65535) m_bytes++;
                fwd_exp++;
            end else if (vld && eol) begin
                if (m_bytes != m_llen) errs[0] = 1'b1;
                m_bytes = 0;
                m_lines++;
                if (m_lines == m_fh) begin
                    done = 1; m_fcnt++; m_frame = 0;
                    if (m_single || m_pend) begin m_on = 0; m_pend = 0; end
                end
            end
        end
        m_flags = (clr ? 2'b00 : m_flags) | errs;
        @(posedge clk);
        #1;
        check("busy", busy, m_on);
        check("frame_done", done_o, done);
        check("err_irq", irq_o, errs != 0);
        check("frame_cnt", fcnt_o, m_fcnt);
        check("err_flags", flags_o, m_flags);
        start = 0; stop = 0; clr = 0;
    endtask

    function automatic logic [9:0] pix_e();
        return {2'b01, 8'($urandom)};
    endfunction

    function automatic logic [9:0] sof_e();
        return {1'b1, 1'($urandom), 8'($urandom)};
    endfunction

    function automatic logic [9:0] eol_e();
        return {2'b00, 8'($urandom)};
    endfunction

    // Offer one entry with random upstream gaps and downstream stalls until the model sees it consumed
    task automatic send(input logic [9:0] e, input bit det = 0);
        int n = 0;
        do begin
            vld = det || n > 6 || $urandom_range(0, 3) != 0;
            rdy_i = det || n > 6 || $urandom_range(0, 3) != 0;
            info = vld ? e : 10'($urandom);
            tick();
            n++;
        end while (!consumed && n < 20);
        check("send_bound", consumed, 1);
        vld = 0;
    endtask

    task automatic line(input int n);
        repeat (n) send(pix_e());
        send(eol_e());
    endtask

    task automatic ctl(input bit s_start, input bit s_stop, input bit s_clr);
        vld = 0; start = s_start; stop = s_stop; clr = s_clr;
        tick();
    endtask

    task automatic cfg(input bit s, input int l, input int h);
        single = s; llen = 16'(l); fh = 16'(h);
        ctl(1, 0, 0);
    endtask

    initial begin
        int base, g, r, n;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1;

        // Two clean continuous frames of 2 lines x 4 bytes, with junk before the first SOF
        base = fwd_dut;
        cfg(0, 4, 2);
        send(pix_e());
        send(eol_e());
        repeat (2) begin
            send(sof_e());
            repeat (2) line(4);
        end
        ctl(0, 1, 0);
        check("t1_fwd", fwd_dut - base, 16);
        check("t1_fcnt", fcnt_o, 2);
        check("t1_flags", flags_o, 0);

        // Start and stop together in idle: stop wins
        ctl(1, 1, 0);

        // Single-shot 1 x 3, then later traffic is drained
        base = fwd_dut;
        cfg(1, 3, 1);
        send(sof_e());
        line(3);
        send(sof_e());
        line(2);
        check("t2_fwd", fwd_dut - base, 3);
        check("t2_fcnt", fcnt_o, 3);

        // Overlong line, frame still completes
        cfg(0, 4, 2);
        send(sof_e());
        line(5);
        line(4);
        check("t3_flags", flags_o, 2'b01);
        check("t3_fcnt", fcnt_o, 4);
        ctl(0, 1, 1);

        // SOF after one of three lines, then a full frame; start while busy is ignored
        cfg(0, 2, 3);
        send(sof_e());
        line(2);
        send(sof_e());
        llen = 16'd7;
        ctl(1, 0, 0);
        repeat (3) line(2);
        check("t4_flags", flags_o, 2'b10);
        check("t4_fcnt", fcnt_o, 5);

        // Downstream stall mid-line, then a clear colliding with a new line error
        send(sof_e());
        send(pix_e());
        vld = 1; rdy_i = 0; info = pix_e();
        repeat (10) tick();
        rdy_i = 1;
        tick();
        send(pix_e(), 1);
        clr = 1;
        send(eol_e(), 1);
        check("t5_flags", flags_o, 2'b01);
        check("t5_fwd", fwd_dut, fwd_exp);
        ctl(0, 1, 1);
        repeat (2) line(2);

        // Randomized sessions with bad lines, short frames, stops, clears and ignored starts
        repeat (25) begin
            cfg($urandom_range(0, 1), $urandom_range(1, 5), $urandom_range(1, 3));
            g = 0;
            while (m_on && g < 40) begin
                g++;
                if (g == 13) ctl(0, 1, 0);
                if (!m_on) break;
                if (!m_frame) begin
                    if ($urandom_range(0, 2) == 0) send(pix_e());
                    send(sof_e());
                end else begin
                    r = $urandom_range(g > 12 ? 4 : 0, 15);
                    n = ($urandom_range(0, 3) == 0) ? $urandom_range(0, m_llen + 1) : m_llen;
                    if (r == 0) send(sof_e());
                    else if (r == 1) ctl(0, 1, 0);
                    else if (r == 2) ctl(0, 0, 1);
                    else if (r == 3) ctl(1, 0, 0);
                    else line(n);
                end
            end
            check("rand_idle", busy, 0);
        end
        check("rand_fwd", fwd_dut, fwd_exp);

        // Stop mid-frame completes the frame first
        ctl(0, 0, 1);
        cfg(0, 4, 2);
        send(sof_e());
        line(4);
        ctl(0, 1, 0);
        send(pix_e());
        check("t6_busy_pend", busy, 1);
        line(3);
        check("t6_idle", busy, 0);

        // Asynchronous reset mid-line takes effect immediately
        cfg(0, 4, 2);
        send(sof_e());
        send(pix_e());
        vld = 1; rdy_i = 0; info = pix_e();
        #2;
        check("pre_rst_rdy", rdy_o, 0);
        rst_n = 0;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        vld = 0;
        @(negedge clk);
        rst_n = 1;
        cfg(1, 1, 1);
        send(sof_e());
        line(1);
        check("post_rst_fcnt", fcnt_o, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
        $fatal(1);
    end

endmodule
